// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state codes, stream framing and checksum width.
// Checksum support is compiled in with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CSUM_W     = 8;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_LEN_LO = 3'd1;
   localparam state_t S_LEN_HI = 3'd2;
   localparam state_t S_DATA   = 3'd3;
   localparam state_t S_CSUM   = 3'd4;
   localparam state_t S_DRAIN  = 3'd5;
   localparam state_t S_DONE   = 3'd6;
   localparam state_t S_ERROR  = 3'd7;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs little-endian bytes into 32-bit words; optional running byte sum.
// Checksum accumulator present only with IMEM_LOADER_CHECKSUM_EN.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        byte_last_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [CSUM_W-1:0] sum_o
`endif
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] pack_q, pack_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;

   assign byte_last_o  = (cnt_q == 2'(WORD_BYTES - 1));
   assign word_valid_o = valid_q;
   assign word_o       = word_q;

   // Earlier bytes enter from the top so the first byte ends up in [7:0].
   always_comb begin
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      word_d  = word_q;
      valid_d = byte_en_i && byte_last_o;
      if (clr_i) begin
         cnt_d  = '0;
         pack_d = '0;
      end else if (byte_en_i) begin
         cnt_d  = cnt_q + 2'd1;
         pack_d = {byte_i, pack_q[23:8]};
         if (byte_last_o) word_d = {byte_i, pack_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pack_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] sum_q, sum_d;

   assign sum_o = sum_q;

   always_comb begin
      sum_d = sum_q;
      if (clr_i) sum_d = '0;
      else if (byte_en_i) sum_d = sum_q + byte_i;
   end

   always_ff @(posedge clk) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
   end
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> imem writes, holding the core until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int BASE_ADDR      = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_addr,
   output logic [31:0]       write_data,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error
);

   localparam int LenW = LEN_BYTES * 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AfterData = S_CSUM;
`else
   localparam state_t AfterData = S_DRAIN;
`endif

   state_t            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [LenW-1:0]   len_q, len_d;
   logic [LenW-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       idle_q, idle_d;

   logic            accept, data_byte, clr, byte_last;
   logic            word_last, len_bad, tmo;
   logic [LenW-1:0] len_n;

   assign s_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI)
                 || (state_q == S_DATA)   || (state_q == S_CSUM);
   assign accept    = s_valid && s_ready;
   assign data_byte = accept && (state_q == S_DATA);
   assign len_n     = {s_data, len_lo_q};
   assign len_bad   = 33'(len_n) > (33'd1 << ADDR_W);
   assign word_last = byte_last
                   && ((17'(wcnt_q) + 17'd1) == 17'(len_q));
   assign tmo = (TIMEOUT_CYCLES != 0)
             && ((idle_q + 32'd1) == 32'(TIMEOUT_CYCLES));

   assign write_addr = addr_q;
   assign core_hold  = (state_q != S_DONE);
   assign load_done  = (state_q == S_DONE);
   assign load_error = (state_q == S_ERROR);

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] sum;
   logic              csum_ok;

   assign csum_ok = ((sum + s_data) == '0);
`endif

   imem_word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr),
      .byte_en_i    (data_byte),
      .byte_i       (s_data),
      .byte_last_o  (byte_last),
      .word_valid_o (write_en),
      .word_o       (write_data)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .sum_o        (sum)
`endif
   );

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      wcnt_d   = wcnt_q;
      addr_d   = addr_q;
      clr      = 1'b0;
      idle_d   = (!s_ready || accept) ? '0 : idle_q + 32'd1;
      if (write_en) addr_d = addr_q + 1'b1;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_LO;
               clr     = 1'b1;
               wcnt_d  = '0;
               addr_d  = ADDR_W'(BASE_ADDR);
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_lo_d = s_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = len_n;
               if (len_bad)         state_d = S_ERROR;
               else if (len_n == 0) state_d = AfterData;
               else                 state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (data_byte && byte_last) begin
               wcnt_d = wcnt_q + 1'b1;
               if (word_last) state_d = AfterData;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) state_d = csum_ok ? S_DRAIN : S_ERROR;
         end
`endif
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      // An accepted byte beats a coincident timeout.
      if (s_ready && !accept && tmo) state_d = S_ERROR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         wcnt_q   <= '0;
         addr_q   <= ADDR_W'(BASE_ADDR);
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         wcnt_q   <= wcnt_d;
         addr_q   <= addr_d;
         idle_q   <= idle_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random images, wrap, bad length,
// timeout, reset mid-load; checksum cases when IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int AW   = 4;
   localparam int BASE = 14;
   localparam int TMO  = 8;
   localparam int MEMW = 1 << AW;

   logic          clk = 1'b0;
   logic          rst, start, s_valid;
   logic [7:0]    s_data;
   logic          s_ready, write_en;
   logic [AW-1:0] write_addr;
   logic [31:0]   write_data;
   logic          core_hold, load_done, load_error;

   imem_loader #(
      .ADDR_W         (AW),
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .core_hold  (core_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   int          vectors = 0;
   int          miscompares = 0;
   wr_t         sb[$];
   logic [31:0] words[MEMW];
   int          gap_mode = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   wr_t e;
   always @(negedge clk) begin
      if (write_en === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected none",
                     write_addr, write_data);
         end else begin
            e = sb.pop_front();
            check("write_addr", 32'(write_addr), 32'(e.addr));
            check("write_data", write_data, e.data);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int g;
      int k;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (g > 0) begin
         repeat (g) @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (s_ready) break;
      end
      if (k == 40) begin
         $display("FAIL s_ready_wait: got no s_ready, expected ready within 40 cycles");
         $fatal(1, "handshake stuck");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_load(input int n, input bit bad);
      logic [7:0] sum;
      logic [7:0] b;
      logic [7:0] c;
      sum = 8'd0;
      pulse_start();
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            b = words[i][8*j +: 8];
            sum = sum + b;
            if (j == 3) sb.push_back('{(BASE + i) % MEMW, words[i]});
            send_byte(b);
         end
      end
      c = 8'd0 - sum;
      if (bad) c = c + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(c);
`endif
      @(negedge clk);
      if (bad) begin
         check("csum_error", 32'(load_error), 32'd1);
         check("csum_hold", 32'(core_hold), 32'd1);
      end else begin
         check("drain_done", 32'(load_done), 32'd0);
         check("drain_hold", 32'(core_hold), 32'd1);
         @(negedge clk);
         check("done", 32'(load_done), 32'd1);
         check("done_hold", 32'(core_hold), 32'd0);
         check("done_err", 32'(load_error), 32'd0);
      end
   endtask

   task automatic load_bad_len(input int n);
      pulse_start();
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      repeat (3) begin
         @(negedge clk);
         check("badlen_error", 32'(load_error), 32'd1);
         check("badlen_hold", 32'(core_hold), 32'd1);
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) words[i] = $urandom;
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_write_en", 32'(write_en), 32'd0);
      check("rst_write_addr", 32'(write_addr), 32'(BASE % MEMW));
      check("rst_write_data", write_data, 32'd0);
      check("rst_core_hold", 32'(core_hold), 32'd1);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      gap_mode = 0;
      do_load(2, 1'b0);
      gap_mode = 1;
      do_load(2, 1'b0);
      gap_mode = 0;
      do_load(0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         gap_mode = r % 3;
         n = int'($urandom_range(1, MEMW));
         fill_random(n);
         do_load(n, 1'b0);
      end
      gap_mode = 0;
      fill_random(MEMW);
      do_load(MEMW, 1'b0);

      load_bad_len(MEMW + 1);
      load_bad_len(32'h8000);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words[0] = 32'h0000_0013;
      do_load(1, 1'b1);
      do_load(1, 1'b0);
`endif

      fill_random(2);
      pulse_start();
      send_byte(8'd2);
      send_byte(8'd0);
      send_byte(words[0][7:0]);
      send_byte(words[0][15:8]);
      repeat (TMO - 1) @(posedge clk);
      @(negedge clk);
      check("tmo_not_yet", 32'(load_error), 32'd0);
      @(negedge clk);
      check("tmo_error", 32'(load_error), 32'd1);
      check("tmo_s_ready", 32'(s_ready), 32'd0);
      fill_random(2);
      do_load(2, 1'b0);

      fill_random(4);
      pulse_start();
      send_byte(8'd4);
      send_byte(8'd0);
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{(BASE + i) % MEMW, words[i]});
         for (int j = 0; j < 4; j++) send_byte(words[i][8*j +: 8]);
      end
      send_byte(words[2][7:0]);
      send_byte(words[2][15:8]);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      check("midrst_hold", 32'(core_hold), 32'd1);
      check("midrst_done", 32'(load_done), 32'd0);
      check("midrst_error", 32'(load_error), 32'd0);
      s_valid = 1'b1;
      s_data  = 8'hA5;
      repeat (10) begin
         @(negedge clk);
         check("midrst_idle_ready", 32'(s_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      fill_random(3);
      do_load(3, 1'b0);

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
